// File: rtl/ddr3_wb_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter in front of ddr3_top.
package ddr3_wb_arbiter_pkg;

  typedef enum logic {
    MASTER_A = 1'b0,
    MASTER_B = 1'b1
  } master_e;

  localparam int MAX_PENDING_DEFAULT = 8;

  function automatic int pend_bits(input int max_pending);
    return $clog2(max_pending);
  endfunction

  function automatic master_e other_master(input master_e m);
    return (m == MASTER_A) ? MASTER_B : MASTER_A;
  endfunction

endpackage

// File: rtl/wb_id_fifo.sv
// In-order owner-ID FIFO: 1 bit wide, first-word-fall-through head, flushable.
module wb_id_fifo
  import ddr3_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_PENDING_DEFAULT
) (
  input  logic i_controller_clk,
  input  logic i_rst,
  input  logic flush,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PEND_BITS = pend_bits(DEPTH);

  logic                 mem [DEPTH];
  logic [PEND_BITS-1:0] wr_ptr;
  logic [PEND_BITS-1:0] rd_ptr;
  logic [PEND_BITS:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (PEND_BITS+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_controller_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PEND_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PEND_BITS'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PEND_BITS+1)'(1);
        2'b01:   count <= count - (PEND_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge i_controller_clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/ddr3_wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter sharing ddr3_top's port between masters A and B.
module ddr3_wb_arbiter
  import ddr3_wb_arbiter_pkg::*;
#(
  parameter int WB_ADDR_BITS = 24,
  parameter int WB_DATA_BITS = 128,
  parameter int WB_SEL_BITS  = 16,
  parameter int AUX_WIDTH    = 4,
  parameter int MAX_PENDING  = MAX_PENDING_DEFAULT
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst,
  input  logic                    i_a_cyc,
  input  logic                    i_a_stb,
  input  logic                    i_a_we,
  input  logic [WB_ADDR_BITS-1:0] i_a_addr,
  input  logic [WB_DATA_BITS-1:0] i_a_data,
  input  logic [WB_SEL_BITS-1:0]  i_a_sel,
  input  logic [AUX_WIDTH-1:0]    i_a_aux,
  output logic                    o_a_stall,
  output logic                    o_a_ack,
  input  logic                    i_b_cyc,
  input  logic                    i_b_stb,
  input  logic                    i_b_we,
  input  logic [WB_ADDR_BITS-1:0] i_b_addr,
  input  logic [WB_DATA_BITS-1:0] i_b_data,
  input  logic [WB_SEL_BITS-1:0]  i_b_sel,
  input  logic [AUX_WIDTH-1:0]    i_b_aux,
  output logic                    o_b_stall,
  output logic                    o_b_ack,
  output logic [WB_DATA_BITS-1:0] o_rd_data,
  output logic [AUX_WIDTH-1:0]    o_rd_aux,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [WB_ADDR_BITS-1:0] o_wb_addr,
  output logic [WB_DATA_BITS-1:0] o_wb_data,
  output logic [WB_SEL_BITS-1:0]  o_wb_sel,
  output logic [AUX_WIDTH-1:0]    o_wb_aux,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [WB_DATA_BITS-1:0] i_wb_data,
  input  logic [AUX_WIDTH-1:0]    i_wb_aux,
  output logic                    o_protocol_err
);

  master_e owner;
  master_e owner_nxt;
  logic    a_req;
  logic    b_req;
  logic    own_req;
  logic    other_req;
  logic    accept;
  logic    pop;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_head;

  assign a_req     = i_a_cyc & i_a_stb;
  assign b_req     = i_b_cyc & i_b_stb;
  assign own_req   = (owner == MASTER_B) ? b_req : a_req;
  assign other_req = (owner == MASTER_B) ? a_req : b_req;

  assign o_wb_cyc  = i_a_cyc | i_b_cyc;
  assign o_wb_stb  = own_req & ~fifo_full & ~i_rst;
  assign accept    = o_wb_stb & ~i_wb_stall;

  assign o_a_stall = (owner == MASTER_A) ? (i_wb_stall | fifo_full) : 1'b1;
  assign o_b_stall = (owner == MASTER_B) ? (i_wb_stall | fifo_full) : 1'b1;

  always_comb begin
    o_wb_we   = i_a_we;
    o_wb_addr = i_a_addr;
    o_wb_data = i_a_data;
    o_wb_sel  = i_a_sel;
    o_wb_aux  = i_a_aux;
    if (owner == MASTER_B) begin
      o_wb_we   = i_b_we;
      o_wb_addr = i_b_addr;
      o_wb_data = i_b_data;
      o_wb_sel  = i_b_sel;
      o_wb_aux  = i_b_aux;
    end
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) owner <= MASTER_A;
    else       owner <= owner_nxt;
  end

  // NOTE: owner_nxt gets its default before any branch so no latch can be inferred.
  always_comb begin
    owner_nxt = owner;
    if ((accept || !own_req) && other_req) owner_nxt = other_master(owner);
  end

  // Acks follow FIFO order; a master that has dropped cyc still pops but sees no ack.
  assign pop       = i_wb_ack & ~fifo_empty;
  assign o_a_ack   = pop & (fifo_head == MASTER_A) & i_a_cyc;
  assign o_b_ack   = pop & (fifo_head == MASTER_B) & i_b_cyc;
  assign o_rd_data = i_wb_data;
  assign o_rd_aux  = i_wb_aux;

  always_ff @(posedge i_controller_clk) begin
    if (i_rst)                        o_protocol_err <= 1'b0;
    else if (i_wb_ack && fifo_empty)  o_protocol_err <= 1'b1;
  end

  wb_id_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_id_fifo (
    .i_controller_clk(i_controller_clk),
    .i_rst           (i_rst),
    .flush           (~o_wb_cyc),
    .push            (accept),
    .push_id         (logic'(owner)),
    .pop             (pop),
    .head            (fifo_head),
    .full            (fifo_full),
    .empty           (fifo_empty)
  );

endmodule
